// File: rtl/sd_spi_pkg.sv
// Shared constants for the SPI-mode SD card responder: command indices,
// R1 bit positions, response lengths and the receive/transmit state encoding.
package sd_spi_pkg;

  localparam logic [5:0] CMD_GO_IDLE         = 6'd0;
  localparam logic [5:0] CMD_SEND_IF_COND    = 6'd8;
  localparam logic [5:0] CMD_SD_SEND_OP_COND = 6'd41;
  localparam logic [5:0] CMD_APP_CMD         = 6'd55;
  localparam logic [5:0] CMD_READ_OCR        = 6'd58;

  // R1 bit positions as seen by the host (bit 7 is always the 0 start bit)
  localparam int R1_IN_IDLE = 0;
  localparam int R1_ILLEGAL = 2;
  localparam int R1_CRC_ERR = 3;

  localparam logic [5:0] RESP_LEN_R1   = 6'd8;
  localparam logic [5:0] RESP_LEN_LONG = 6'd40;

  typedef enum logic [2:0] {
    RX_IDLE  = 3'd0,
    RX_SHIFT = 3'd1,
    DECODE   = 3'd2,
    NCR_WAIT = 3'd3,
    TX_SHIFT = 3'd4
  } sd_state_t;

  function automatic logic [7:0] r1_byte(input logic crc_err, input logic illegal,
                                         input logic in_idle);
    logic [7:0] r;
    r             = 8'h00;
    r[R1_CRC_ERR] = crc_err;
    r[R1_ILLEGAL] = illegal;
    r[R1_IN_IDLE] = in_idle;
    return r;
  endfunction

endpackage

// File: rtl/sd_crc7.sv
// Serial CRC7 (x^7 + x^3 + 1), zero initial value, one message bit per enable.
module sd_crc7 (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_clr,
  input  logic       i_en,
  input  logic       i_bit,
  output logic [6:0] o_crc
);

  logic [6:0] r_crc;
  logic       w_fb;

  assign w_fb  = i_bit ^ r_crc[6];
  assign o_crc = r_crc;

  // Shift register with feedback taps at x^3 and x^0.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_crc <= 7'h00;
    end else if (i_en) begin
      r_crc <= {r_crc[5:3], r_crc[2] ^ w_fb, r_crc[1:0], w_fb};
    end
  end

endmodule

// File: rtl/sd_spi_card_responder.sv
// Card-side SPI-mode SD responder: oversampled SPI front end, 48-bit command
// deframer with CRC7 check, and R1/R7/R3 response generator.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// RX_IDLE  | waiting for a 0 start bit with CS_n low
// RX_SHIFT | shifting the remaining 47 command bits on SCK rises
// DECODE   | one cycle: check frame, update card state, load response
// NCR_WAIT | MISO held high for NCR_BYTES*8 SCK falls
// TX_SHIFT | response shifted out MSB first, one bit per SCK fall
module sd_spi_card_responder
  import sd_spi_pkg::*;
#(
  parameter int          NCR_BYTES       = 1,
  parameter int          ACMD41_BUSY_CNT = 2,
  parameter logic [23:0] OCR_VDD         = 24'hFF8000,
  parameter int          SYNC_STAGES     = 2
) (
  input  logic        resp_clk_i,
  input  logic        resp_rst_i,
  input  logic        spi_sck_i,
  input  logic        spi_cs_n_i,
  input  logic        spi_mosi_i,
  output logic        spi_miso_o,
  output logic        cmd_valid_o,
  output logic [5:0]  cmd_index_o,
  output logic [31:0] cmd_arg_o,
  output logic        crc_err_o,
  output logic        card_ready_o
);

  localparam logic [6:0] NCR_FALLS = 7'(NCR_BYTES * 8);
  localparam logic [3:0] BUSY_MAX  = 4'(ACMD41_BUSY_CNT);

  logic [SYNC_STAGES-1:0] r_sck_sync, r_cs_sync, r_mosi_sync;
  logic        r_sck_prev;
  sd_state_t   r_state, w_next;
  logic [46:0] r_rx_sr;
  logic [5:0]  r_bit_cnt, r_tx_cnt;
  logic [6:0]  r_ncr_cnt;
  logic [39:0] r_tx_sr;
  logic        r_miso, r_cmd_valid, r_crc_err, r_in_idle, r_card_ready, r_app_flag;
  logic [5:0]  r_cmd_index;
  logic [31:0] r_cmd_arg;
  logic [3:0]  r_busy_cnt;

  logic        w_sck, w_cs_n, w_mosi, w_rise, w_fall, w_start;
  logic        w_crc_clr, w_crc_en, w_frame_err, w_illegal;
  logic [6:0]  w_crc;
  logic [5:0]  w_idx;
  logic [31:0] w_arg;
  logic        w_in_idle_nxt, w_ready_nxt, w_app_nxt;
  logic [3:0]  w_busy_nxt;
  logic [7:0]  w_r1;
  logic [39:0] w_resp;
  logic [5:0]  w_resp_len;

  assign w_sck   = r_sck_sync[SYNC_STAGES-1];
  assign w_cs_n  = r_cs_sync[SYNC_STAGES-1];
  assign w_mosi  = r_mosi_sync[SYNC_STAGES-1];
  assign w_rise  = !r_sck_prev && w_sck;
  assign w_fall  = r_sck_prev && !w_sck;
  assign w_start = (r_state == RX_IDLE) && !w_cs_n && w_rise && !w_mosi;
  assign w_idx   = r_rx_sr[45:40];
  assign w_arg   = r_rx_sr[39:8];

  // CRC covers frame bits 47..8: the start bit plus the first 39 shifted bits.
  assign w_crc_clr = (r_state == RX_IDLE) && !w_start;
  assign w_crc_en  = w_start || (!w_cs_n && w_rise && (r_state == RX_SHIFT) && (r_bit_cnt < 6'd40));

  sd_crc7 u_crc7 (
    .i_clk (resp_clk_i),
    .i_rst (resp_rst_i),
    .i_clr (w_crc_clr),
    .i_en  (w_crc_en),
    .i_bit (w_mosi),
    .o_crc (w_crc)
  );

  // Input synchronizers and SCK edge history.
  always_ff @(posedge resp_clk_i) begin
    if (resp_rst_i) begin
      r_sck_sync  <= '0;
      r_cs_sync   <= '1;
      r_mosi_sync <= '1;
      r_sck_prev  <= 1'b0;
    end else begin
      r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], spi_sck_i};
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], spi_cs_n_i};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], spi_mosi_i};
      r_sck_prev  <= w_sck;
    end
  end

  // Frame check and response build; only consumed while in DECODE.
  always_comb begin
    w_frame_err   = !r_rx_sr[46] || !r_rx_sr[0] ||
                    (((w_idx == CMD_GO_IDLE) || (w_idx == CMD_SEND_IF_COND)) && (w_crc != r_rx_sr[7:1]));
    w_in_idle_nxt = r_in_idle;
    w_ready_nxt   = r_card_ready;
    w_busy_nxt    = r_busy_cnt;
    w_app_nxt     = 1'b0;
    w_illegal     = 1'b0;
    w_resp_len    = RESP_LEN_R1;
    if (!w_frame_err) begin
      case (w_idx)
        CMD_GO_IDLE: begin
          w_in_idle_nxt = 1'b1;
          w_ready_nxt   = 1'b0;
          w_busy_nxt    = 4'd0;
        end
        CMD_SEND_IF_COND: w_resp_len = RESP_LEN_LONG;
        CMD_APP_CMD:      w_app_nxt  = 1'b1;
        CMD_SD_SEND_OP_COND: begin
          if (!r_app_flag) begin
            w_illegal = 1'b1;
          end else if (r_busy_cnt < BUSY_MAX) begin
            w_busy_nxt    = r_busy_cnt + 4'd1;
            w_in_idle_nxt = 1'b1;
          end else begin
            w_in_idle_nxt = 1'b0;
            w_ready_nxt   = 1'b1;
          end
        end
        CMD_READ_OCR: w_resp_len = RESP_LEN_LONG;
        default:      w_illegal  = 1'b1;
      endcase
    end
    w_r1   = r1_byte(w_frame_err, w_illegal, w_in_idle_nxt);
    w_resp = {w_r1, 32'h0};
    if (!w_frame_err && (w_idx == CMD_SEND_IF_COND)) w_resp = {w_r1, 20'h0, w_arg[11:0]};
    if (!w_frame_err && (w_idx == CMD_READ_OCR)) w_resp = {w_r1, w_ready_nxt, w_ready_nxt, 6'b0, OCR_VDD};
  end

  // State register.
  always_ff @(posedge resp_clk_i) begin
    if (resp_rst_i) r_state <= RX_IDLE;
    else            r_state <= w_next;
  end

  // Next-state logic; a deasserted chip select overrides everything.
  always_comb begin
    w_next = r_state;
    if (w_cs_n) begin
      w_next = RX_IDLE;
    end else begin
      case (r_state)
        RX_IDLE:  if (w_rise && !w_mosi) w_next = RX_SHIFT;
        RX_SHIFT: if (w_rise && (r_bit_cnt == 6'd47)) w_next = DECODE;
        DECODE:   w_next = NCR_WAIT;
        NCR_WAIT: if (w_fall && (r_ncr_cnt == 7'd0)) w_next = TX_SHIFT;
        TX_SHIFT: if (w_fall && (r_tx_cnt == 6'd0)) w_next = RX_IDLE;
        default:  w_next = RX_IDLE;
      endcase
    end
  end

  // Shift registers, timers, decode outputs and card state.
  always_ff @(posedge resp_clk_i) begin
    if (resp_rst_i) begin
      r_rx_sr      <= '0;
      r_bit_cnt    <= '0;
      r_tx_sr      <= '0;
      r_tx_cnt     <= '0;
      r_ncr_cnt    <= '0;
      r_miso       <= 1'b1;
      r_cmd_valid  <= 1'b0;
      r_crc_err    <= 1'b0;
      r_cmd_index  <= '0;
      r_cmd_arg    <= '0;
      r_in_idle    <= 1'b1;
      r_card_ready <= 1'b0;
      r_app_flag   <= 1'b0;
      r_busy_cnt   <= '0;
    end else begin
      r_cmd_valid <= 1'b0;
      r_crc_err   <= 1'b0;
      if (w_cs_n) begin
        r_miso <= 1'b1;
      end else begin
        case (r_state)
          RX_IDLE: begin
            r_miso <= 1'b1;
            if (w_start) begin
              r_rx_sr   <= {r_rx_sr[45:0], w_mosi};
              r_bit_cnt <= 6'd1;
            end
          end
          RX_SHIFT: begin
            r_miso <= 1'b1;
            if (w_rise) begin
              r_rx_sr   <= {r_rx_sr[45:0], w_mosi};
              r_bit_cnt <= r_bit_cnt + 6'd1;
            end
          end
          DECODE: begin
            r_miso       <= 1'b1;
            r_cmd_valid  <= 1'b1;
            r_crc_err    <= w_frame_err;
            r_cmd_index  <= w_idx;
            r_cmd_arg    <= w_arg;
            r_in_idle    <= w_in_idle_nxt;
            r_card_ready <= w_ready_nxt;
            r_busy_cnt   <= w_busy_nxt;
            r_app_flag   <= w_app_nxt;
            r_tx_sr      <= w_resp;
            r_tx_cnt     <= w_resp_len;
            r_ncr_cnt    <= NCR_FALLS;
          end
          NCR_WAIT, TX_SHIFT: begin
            if (w_fall) begin
              if (r_state == NCR_WAIT && r_ncr_cnt != 7'd0) begin
                r_ncr_cnt <= r_ncr_cnt - 7'd1;
              end else if (r_state == TX_SHIFT && r_tx_cnt == 6'd0) begin
                r_miso <= 1'b1;
              end else begin
                r_miso   <= r_tx_sr[39];
                r_tx_sr  <= {r_tx_sr[38:0], 1'b0};
                r_tx_cnt <= r_tx_cnt - 6'd1;
              end
            end
          end
          default: r_miso <= 1'b1;
        endcase
      end
    end
  end

  assign spi_miso_o   = r_miso;
  assign cmd_valid_o  = r_cmd_valid;
  assign cmd_index_o  = r_cmd_index;
  assign cmd_arg_o    = r_cmd_arg;
  assign crc_err_o    = r_crc_err;
  assign card_ready_o = r_card_ready;

endmodule

// File: tb/tb_sd_spi_card_responder.sv
// Bench for the SD SPI card responder: a host-side bit-banging driver,
// a behavioural card model, and scoreboard monitors for decoded commands
// and for responses read back over MISO.
module tb_sd_spi_card_responder;

  localparam int          NCR  = 1;
  localparam int          BUSY = 2;
  localparam logic [23:0] OCR  = 24'hFF8000;
  localparam int          HALF = 5;

  logic clk = 1'b0, rst = 1'b1, sck = 1'b0, cs_n = 1'b1, mosi = 1'b1;
  logic miso, cmd_valid, crc_err, card_ready;
  logic [5:0]  cmd_index;
  logic [31:0] cmd_arg;

  always #5 clk = ~clk;

  sd_spi_card_responder #(
    .NCR_BYTES(NCR), .ACMD41_BUSY_CNT(BUSY), .OCR_VDD(OCR), .SYNC_STAGES(2)
  ) dut (
    .resp_clk_i   (clk),
    .resp_rst_i   (rst),
    .spi_sck_i    (sck),
    .spi_cs_n_i   (cs_n),
    .spi_mosi_i   (mosi),
    .spi_miso_o   (miso),
    .cmd_valid_o  (cmd_valid),
    .cmd_index_o  (cmd_index),
    .cmd_arg_o    (cmd_arg),
    .crc_err_o    (crc_err),
    .card_ready_o (card_ready)
  );

  typedef struct packed {
    logic [5:0]  idx;
    logic [31:0] arg;
    logic        err;
  } cmd_exp_t;

  cmd_exp_t    q_cmd[$];
  logic [39:0] q_resp_exp[$];
  logic [39:0] q_resp_got[$];
  int n_checks = 0, n_fail = 0, n_valid_seen = 0;

  // card model state
  bit m_idle = 1'b1, m_ready = 1'b0, m_app = 1'b0;
  int m_busy = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // CRC7 as the remainder of polynomial long division of msg*x^7 by 0x89.
  function automatic logic [6:0] crc7(input logic [39:0] d);
    logic [46:0] r;
    r = {d, 7'b0};
    for (int i = 46; i >= 7; i--)
      if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
    return r[6:0];
  endfunction

  function automatic logic [47:0] mk(input logic [5:0] idx, input logic [31:0] arg);
    logic [39:0] h;
    h = {2'b01, idx, arg};
    return {h, crc7(h), 1'b1};
  endfunction

  task automatic model_reset();
    m_idle = 1'b1; m_ready = 1'b0; m_app = 1'b0; m_busy = 0;
  endtask

  task automatic model_cmd(input logic [47:0] f, output logic [39:0] resp,
                           output logic err, output int len);
    logic [5:0]  idx;
    logic [31:0] arg;
    logic        ill;
    logic [7:0]  r1;
    idx = f[45:40];
    arg = f[39:8];
    ill = 1'b0;
    err = !f[46] || !f[0] || ((idx == 0 || idx == 8) && crc7(f[47:8]) != f[7:1]);
    if (!err) begin
      if (idx == 0) begin
        m_idle = 1'b1; m_ready = 1'b0; m_busy = 0;
      end else if (idx == 41 && m_app) begin
        if (m_busy < BUSY) m_busy++;
        else begin m_idle = 1'b0; m_ready = 1'b1; end
      end else if (!(idx == 8 || idx == 55 || idx == 58)) begin
        ill = 1'b1;
      end
    end
    m_app = !err && idx == 55;
    r1    = {4'b0, err, ill, 1'b0, m_idle};
    resp  = {r1, 32'h0};
    len   = 8;
    if (!err && idx == 8)  begin resp = {r1, 20'h0, arg[11:0]}; len = 40; end
    if (!err && idx == 58) begin resp = {r1, m_ready, m_ready, 6'h0, OCR}; len = 40; end
  endtask

  task automatic sck_cycle(input logic b, output logic so);
    mosi = b;
    repeat (HALF) @(negedge clk);
    sck = 1'b1;
    so  = miso;
    repeat (HALF) @(negedge clk);
    sck = 1'b0;
  endtask

  task automatic transact(input logic [47:0] f);
    logic [39:0] exp, got;
    logic err, so, fill;
    int len;
    model_cmd(f, exp, err, len);
    q_cmd.push_back('{idx: f[45:40], arg: f[39:8], err: err});
    q_resp_exp.push_back(exp);
    cs_n = 1'b0;
    repeat (HALF) @(negedge clk);
    for (int i = 47; i >= 0; i--) sck_cycle(f[i], so);
    fill = 1'b1;
    for (int i = 0; i < NCR * 8; i++) begin sck_cycle(1'b1, so); fill = fill & so; end
    check("ncr_filler", fill, 1'b1);
    got = '0;
    for (int i = 0; i < len; i++) begin sck_cycle(1'b1, so); got = {got[38:0], so}; end
    if (len == 8) got = got << 32;
    q_resp_got.push_back(got);
    sck_cycle(1'b1, so);
    check("miso_after_resp", so, 1'b1);
    check("card_ready", card_ready, m_ready);
    cs_n = 1'b1;
    repeat (4 * HALF) @(negedge clk);
  endtask

  // Decoded-command monitor.
  always @(negedge clk) begin
    if (!rst && cmd_valid) begin
      cmd_exp_t e;
      n_valid_seen++;
      if (q_cmd.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL unexpected_cmd_valid: got index %0d with no command outstanding", cmd_index);
      end else begin
        e = q_cmd.pop_front();
        check("cmd_index", cmd_index, e.idx);
        check("cmd_arg", cmd_arg, e.arg);
        check("crc_err", crc_err, e.err);
      end
    end
    if (!rst && crc_err && !cmd_valid) begin
      n_checks++; n_fail++;
      $display("FAIL crc_err_without_valid: got 1 expected 0");
    end
  end

  // Response monitor.
  always @(negedge clk) begin
    if (q_resp_got.size() != 0) begin
      logic [39:0] g;
      g = q_resp_got.pop_front();
      if (q_resp_exp.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL unexpected_response: got %h", g);
      end else begin
        check("response", g, q_resp_exp.pop_front());
      end
    end
  end

  initial begin
    logic so;
    logic [39:0] dexp;
    logic derr;
    int dlen, v0;
    logic [5:0] cmds[6];

    repeat (5) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_miso", miso, 1'b1);
    check("reset_valid", cmd_valid, 1'b0);
    check("reset_crc_err", crc_err, 1'b0);
    check("reset_ready", card_ready, 1'b0);
    check("reset_index", cmd_index, 6'd0);
    check("reset_arg", cmd_arg, 32'd0);

    transact(48'h400000000095);
    transact(48'h48000001AA87);
    transact(48'h400000000094);
    transact(48'h7A00000000FD);
    transact(48'h694000000077);
    for (int k = 0; k < 3; k++) begin
      transact(48'h770000000065);
      transact(48'h694000000077);
    end
    check("ready_after_acmd41", card_ready, 1'b1);
    transact(48'h7A00000000FD);

    // abort after 20 bits, then a complete CMD0
    cs_n = 1'b0;
    repeat (HALF) @(negedge clk);
    for (int i = 47; i >= 28; i--) sck_cycle(mk(6'd0, 32'h0) >> i, so);
    cs_n = 1'b1;
    repeat (6 * HALF) @(negedge clk);
    v0 = n_valid_seen;
    transact(48'h400000000095);
    check("abort_one_valid", n_valid_seen - v0, 1);

    // randomized traffic
    cmds = '{6'd0, 6'd8, 6'd41, 6'd55, 6'd58, 6'd0};
    for (int t = 0; t < 24; t++) begin
      logic [47:0] f;
      int c;
      cmds[5] = 6'($urandom_range(0, 63));
      f = mk(cmds[$urandom_range(0, 5)], $urandom);
      c = $urandom_range(0, 9);
      if (c == 0) f[1]  = ~f[1];
      if (c == 1) f[0]  = 1'b0;
      if (c == 2) f[46] = 1'b0;
      transact(f);
    end

    // reset in the middle of a response
    model_cmd(48'h400000000095, dexp, derr, dlen);
    q_cmd.push_back('{idx: 6'd0, arg: 32'd0, err: 1'b0});
    cs_n = 1'b0;
    repeat (HALF) @(negedge clk);
    for (int i = 47; i >= 0; i--) sck_cycle(mk(6'd0, 32'h0) >> i, so);
    for (int i = 0; i < NCR * 8; i++) sck_cycle(1'b1, so);
    sck_cycle(1'b1, so);
    check("mid_tx_first_bit", so, 1'b0);
    repeat (2) @(negedge clk);
    check("mid_tx_miso_low", miso, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("reset_mid_tx_miso", miso, 1'b1);
    @(negedge clk);
    rst  = 1'b0;
    cs_n = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    check("post_reset_index", cmd_index, 6'd0);
    check("post_reset_ready", card_ready, 1'b0);
    transact(48'h7A00000000FD);

    repeat (20) @(negedge clk);
    check("cmd_queue_drained", q_cmd.size(), 0);
    check("resp_queue_drained", q_resp_exp.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
